// File: rtl/lut4_mask_probe.sv
// rtl/lut4_mask_probe.sv - LUT4 truth-table readback: sweeps din 0..15, rebuilds the 16-bit mask.
// Optional LUT4_MASK_PROBE_CHECK_EN adds exp_mask compare with a registered mismatch flag.
module lut4_mask_probe #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic [3:0]  probe_din,
  input  logic        probe_dout,
  output logic [15:0] mask_out,
  output logic        mask_valid,
  input  logic        mask_ready
`ifdef LUT4_MASK_PROBE_CHECK_EN
  ,
  input  logic [15:0] exp_mask,
  output logic        mismatch
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       shadow_q;
  logic [15:0]       shadow_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (cnt_q == CNT_W'(1)) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == 4'd15) ? DONE : DRIVE;
      DONE:    if (mask_valid && mask_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    probe_din = (state_q == IDLE) ? 4'd0 : idx_q;
  end

  // The shadow absorbs the current sample so the final bit lands in mask_out on the same edge.
  always_comb begin
    shadow_next        = shadow_q;
    shadow_next[idx_q] = probe_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= 4'd0;
      cnt_q      <= '0;
      shadow_q   <= 16'd0;
      mask_out   <= 16'd0;
      mask_valid <= 1'b0;
`ifdef LUT4_MASK_PROBE_CHECK_EN
      mismatch   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q <= 4'd0;
            cnt_q <= SETTLE_LOAD;
          end
        end
        DRIVE: begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        SAMPLE: begin
          shadow_q <= shadow_next;
          if (idx_q == 4'd15) begin
            mask_out   <= shadow_next;
            mask_valid <= 1'b1;
`ifdef LUT4_MASK_PROBE_CHECK_EN
            mismatch   <= (shadow_next != exp_mask);
`endif
          end else begin
            idx_q <= idx_q + 4'd1;
            cnt_q <= SETTLE_LOAD;
          end
        end
        DONE: begin
          if (mask_valid && mask_ready) begin
            mask_valid <= 1'b0;
`ifdef LUT4_MASK_PROBE_CHECK_EN
            mismatch   <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut4_mask_probe.sv
// tb/tb_lut4_mask_probe.sv - scoreboard bench for lut4_mask_probe against a behavioural LUT4.
module tb_lut4_mask_probe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mask_ready = 1'b0;
  logic        busy;
  logic [3:0]  probe_din;
  logic        probe_dout;
  logic [15:0] mask_out;
  logic        mask_valid;
  logic [15:0] lut_mask = 16'h0000;
`ifdef LUT4_MASK_PROBE_CHECK_EN
  logic [15:0] exp_mask = 16'h0000;
  logic        mismatch;
`endif

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errs = 0;
  int          t_start = 0;
  int          t_valid = 0;
  logic [15:0] exp_q[$];

  assign probe_dout = lut_mask[probe_din];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lut4_mask_probe #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .probe_din  (probe_din),
    .probe_dout (probe_dout),
    .mask_out   (mask_out),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready)
`ifdef LUT4_MASK_PROBE_CHECK_EN
    ,
    .exp_mask   (exp_mask),
    .mismatch   (mismatch)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pulse_start(input logic [15:0] exp);
    @(negedge clk);
    start = 1'b1;
    t_start = cyc;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    logic [15:0] m0;
    logic        partial_seen;
    logic        ok;
    m0 = mask_out;
    partial_seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mask_valid) begin
        ok = 1'b1;
        break;
      end
      if (mask_out !== m0) partial_seen = 1'b1;
      @(negedge clk);
    end
    check("valid_timeout", {31'd0, ok}, 32'd1);
    check("no_partial", {31'd0, partial_seen}, 32'd0);
    if (ok) begin
      t_valid = cyc;
      check("sb_depth", exp_q.size(), 32'd1);
      if (exp_q.size() != 0) check("mask_out", {16'd0, mask_out}, {16'd0, exp_q.pop_front()});
    end
  endtask

  task automatic handshake();
    mask_ready = 1'b1;
    @(negedge clk);
    mask_ready = 1'b0;
    check("hs_valid", {31'd0, mask_valid}, 32'd0);
    check("hs_busy", {31'd0, busy}, 32'd0);
    check("hs_probe_din", {28'd0, probe_din}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_probe_din", {28'd0, probe_din}, 32'd0);
    check("rst_mask_out", {16'd0, mask_out}, 32'd0);
    check("rst_mask_valid", {31'd0, mask_valid}, 32'd0);
`ifdef LUT4_MASK_PROBE_CHECK_EN
    check("rst_mismatch", {31'd0, mismatch}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-ones LUT, ready held high: single-cycle valid and fixed latency
    lut_mask = 16'hFFFF;
    mask_ready = 1'b1;
    pulse_start(16'hFFFF);
    wait_valid(200);
    check("latency_ffff", t_valid - t_start, 32'd49);
    @(negedge clk);
    check("valid_one_cycle", {31'd0, mask_valid}, 32'd0);
    check("busy_low_after", {31'd0, busy}, 32'd0);
    check("mask_retained", {16'd0, mask_out}, 32'h0000FFFF);
    mask_ready = 1'b0;

    // AND4: probe_din walks 0..15, each held SETTLE_CYCLES+1 cycles
    lut_mask = 16'h8000;
    pulse_start(16'h8000);
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 3; k++) begin
        check("probe_din_step", {28'd0, probe_din}, i);
        @(negedge clk);
      end
    end
    wait_valid(200);
    check("latency_8000", t_valid - t_start, 32'd49);
    handshake();

    // XOR4 with back-pressure; starts during hold and on the handshake edge are dropped
    lut_mask = 16'h6996;
    pulse_start(16'h6996);
    wait_valid(200);
    for (int i = 0; i < 20; i++) begin
      check("hold_valid", {31'd0, mask_valid}, 32'd1);
      check("hold_mask", {16'd0, mask_out}, 32'h00006996);
      check("hold_busy", {31'd0, busy}, 32'd1);
      start = (i == 5);
      @(negedge clk);
    end
    start = 1'b0;
    mask_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mask_ready = 1'b0;
    check("hs_start_valid", {31'd0, mask_valid}, 32'd0);
    check("hs_start_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("start_not_queued", {31'd0, busy}, 32'd0);
    check("mask_after_hs", {16'd0, mask_out}, 32'h00006996);

    // Reset mid-sweep at idx 7
    lut_mask = 16'h00FF;
    pulse_start(16'h00FF);
    repeat (21) @(negedge clk);
    check("pre_rst_probe_din", {28'd0, probe_din}, 32'd7);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_probe_din", {28'd0, probe_din}, 32'd0);
    check("abort_mask_out", {16'd0, mask_out}, 32'd0);
    check("abort_valid", {31'd0, mask_valid}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(16'h00FF);
    wait_valid(200);
    handshake();

    // Back-to-back sweeps with the LUT reprogrammed in between
    lut_mask = 16'hA5A5;
    pulse_start(16'hA5A5);
    wait_valid(200);
    handshake();
    lut_mask = 16'h1234;
    pulse_start(16'h1234);
    wait_valid(200);
    handshake();

`ifdef LUT4_MASK_PROBE_CHECK_EN
    lut_mask = 16'hCAFE;
    exp_mask = 16'hCAFF;
    pulse_start(16'hCAFE);
    wait_valid(200);
    check("mismatch_set", {31'd0, mismatch}, 32'd1);
    handshake();
    check("mismatch_clr_hs", {31'd0, mismatch}, 32'd0);
    exp_mask = 16'hCAFE;
    pulse_start(16'hCAFE);
    wait_valid(200);
    check("mismatch_match", {31'd0, mismatch}, 32'd0);
    handshake();
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/lut4_mask_probe.md
Name: lut4_mask_probe

Overview:
- Sequential readback engine for a 4-input LUT cell: drives all 16 input combinations onto the LUT inputs, samples the single LUT output, and rebuilds the 16-bit truth-table mask.
- Sits next to LUT4 instances in self-test and characterisation wrappers.
- Recovers the configured lut_function at run time for comparison against the intended value.

Parameters:
- SETTLE_CYCLES, 2, cycles each input combination is held before dout is sampled; legal range 1..255.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- busy  output  1  high in DRIVE, SAMPLE and DONE.
- probe_din  output  4  LUT input vector; bit0->din0, bit1->din1, bit2->din2, bit3->din3.
- probe_dout  input  1  LUT output (dout) under test.
- mask_out  output  16  recovered mask; bit i = dout observed with probe_din == i.
- mask_valid  output  1  recovered mask available.
- mask_ready  input  1  consumer accepts mask_out.

Behaviour:
- Reset: asynchronous, active-low. While rst_n is low, state=IDLE, probe_din=0, mask_out=0, mask_valid=0, busy=0, and index/counter registers are 0.
- Index convention matches the LUT select order: mask bit {din3,din2,din1,din0}. Example: bit 8 = din3=1, others 0.
- IDLE:
  - probe_din=0, busy=0.
  - start=1 at edge T -> DRIVE. At T+1: probe_din=0, idx=0, settle count=SETTLE_CYCLES.
- DRIVE:
  - probe_din=idx; counter decrements each cycle.
  - After SETTLE_CYCLES cycles in DRIVE -> SAMPLE.
- SAMPLE (1 cycle):
  - At the edge leaving SAMPLE, probe_dout is written into shadow bit idx.
  - If idx<15: idx increments, counter reloads, next state DRIVE; probe_din shows the new idx on the next cycle.
  - If idx==15: shadow -> mask_out, mask_valid=1, next state DONE.
- Per-combination time: SETTLE_CYCLES+1 cycles. mask_valid rises at T+1+16*(SETTLE_CYCLES+1); 49 cycles with the default.
- DONE:
  - mask_out and mask_valid are held stable until mask_valid&&mask_ready at an edge.
  - On that edge: mask_valid=0 and state -> IDLE. mask_out retains its value afterward.
  - probe_din holds 15 until the return to IDLE, then goes to 0.
- start while busy (DRIVE, SAMPLE, DONE): ignored; not queued.
- start in the same cycle as the DONE handshake: ignored; a new sweep needs start in IDLE.
- mask_ready outside DONE: no effect.
- mask_out is updated only once per sweep, at completion, never partially during a sweep.
- Reset asserted mid-sweep: immediate abort to reset values; partial shadow is discarded.
- idx is 4 bits and never wraps; the terminal check is idx==15, not overflow.

Optional Feature:
- Macro: LUT4_MASK_PROBE_CHECK_EN.
- When defined:
  - Adds input exp_mask[15:0] and output mismatch (1 bit).
  - mismatch is registered: set together with mask_valid when the recovered mask != exp_mask; otherwise cleared at that edge.
  - mismatch is cleared on reset and at the DONE handshake.
  - exp_mask is sampled at the completing edge.
- When not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
- LUT with mask 16'hFFFF, SETTLE_CYCLES=2, start pulse at cycle 10, mask_ready=1 -> mask_valid high at cycle 59 for one cycle, mask_out=16'hFFFF, busy low at cycle 60.
- LUT with mask 16'h8000 (AND4) -> mask_out=16'h8000. probe_din steps 0..15, each value held 3 cycles.
- LUT with mask 16'h6996 (XOR4), mask_ready=0 for 20 cycles after valid -> mask_out=16'h6996 stable and valid held 20 cycles. A start pulse during the hold is ignored.
- Mask 16'h00FF, rst_n pulsed low when idx=7 -> all outputs 0 immediately. A new start yields 16'h00FF, never a partial value.
- Back-to-back: first sweep on mask 16'hA5A5, handshake, then the LUT mask is changed to 16'h1234 and start issued -> second mask_out=16'h1234.
- With LUT4_MASK_PROBE_CHECK_EN: LUT mask 16'hCAFE and exp_mask=16'hCAFF -> mismatch=1 with mask_valid. exp_mask=16'hCAFE -> mismatch=0.
